moore_seq_decoder: RTL and testbench
====================================

# moore_seq_decoder

Receive-side decoder for the 2-bit cyclic code stream produced by our Moore sequence generator, whose legal code cycle is 1→2→3→1. It samples the code each valid cycle and classifies every change as a legal advance, a hold or an illegal transition. It runs a lock state machine and counts recovered advance events. It sits downstream of the generator and recovers its `in`-driven stepping from the observed outputs.

## Interface
- `LOCK_COUNT`, default 3: consecutive legal advances in ACQUIRE needed to enter LOCKED; legal range 1..15.
- `ERR_LIMIT`, default 2: consecutive errors, counted from the first error in LOCKED, that drop from RECOVER to SEARCH; legal range 2..15.
- `CNT_W`, default 8: width of `step_count`.
- `clk`, input, 1: clock; all logic on posedge.
- `rst`, input, 1: synchronous, active-high reset.
- `code_in`, input, 2: observed generator code.
- `code_valid`, input, 1: `code_in` is sampled only when high.
- `step`, output, 1: one-cycle pulse for a legal advance.
- `hold`, output, 1: one-cycle pulse for a valid sample equal to `last_code`.
- `err`, output, 1: one-cycle pulse for an illegal transition.
- `locked`, output, 1: high while state is LOCKED or RECOVER.
- `state`, output, 2: current FSM state (SEARCH=0, ACQUIRE=1, LOCKED=2, RECOVER=3).
- `last_code`, output, 2: last accepted reference code.
- `step_count`, output, CNT_W: total advances since reset; wraps modulo 2^CNT_W.

## Operation
- Successor function: succ(1)=2, succ(2)=3, succ(3)=1. Code 0 is never a legal successor.
- Sample classification, evaluated only when `code_valid`=1:
  - `code_in == last_code` → HOLD.
  - `code_in == succ(last_code)` → STEP.
  - Anything else, including code 0 and a skip such as 1→3, → ERR.
- SEARCH:
  - Nonzero sample: load `last_code`, go to ACQUIRE, clear `good_cnt`. No pulse.
  - Code 0: ignored. No `err`.
- ACQUIRE:
  - STEP: `step` pulse, `step_count`++, `last_code`←code, `good_cnt`++. When `good_cnt` reaches `LOCK_COUNT`, go to LOCKED.
  - HOLD: `hold` pulse; counters unchanged.
  - ERR: `err` pulse, `good_cnt`←0. Nonzero code: `last_code`←code (resync). Code 0: go to SEARCH.
- LOCKED:
  - STEP: `step` pulse, `step_count`++, `last_code`←code.
  - HOLD: `hold` pulse.
  - ERR: `err` pulse, `bad_cnt`←1, `last_code`←code if nonzero (unchanged if code 0), go to RECOVER.
- RECOVER:
  - STEP: `step` pulse, `step_count`++, `last_code`←code, `bad_cnt`←0, go to LOCKED.
  - HOLD: `hold` pulse; `bad_cnt` unchanged.
  - ERR: `err` pulse, `bad_cnt`++, resync as in LOCKED. When `bad_cnt` reaches `ERR_LIMIT`, go to SEARCH and clear `last_code` and `good_cnt`.
- `code_valid`=0: no classification, no pulses; all state and counters hold.
- Exactly one of `step`/`hold`/`err` is high per valid sample outside SEARCH. None are high in SEARCH.
- `step_count` is never cleared except by `rst`; it wraps from 2^CNT_W−1 to 0.

## Timing
- All outputs are registered. A sample taken at edge N produces its pulse, `state`, `last_code` and `step_count` update, all visible after edge N. Latency is 1 cycle.
- Pulses last exactly one cycle. Back-to-back valid samples give back-to-back pulses.
- Reset values: `step`=`hold`=`err`=`locked`=0, `state`=SEARCH, `last_code`=0, `step_count`=0. Internal `good_cnt`=`bad_cnt`=0.
- `rst` takes priority over `code_valid`. Reset mid-operation discards any pending classification, and no pulse is emitted for the reset cycle.
- `locked` is derived from the registered state, so it rises in the same cycle the state becomes LOCKED.

## Structure
- Package `moore_seq_pkg` holds:
  - the state encoding constants;
  - code constants CODE_A=1, CODE_B=2, CODE_C=3;
  - the succ function;
  - the classification constants HOLD/STEP/ERR.
- Sub-module `moore_code_classifier`: combinational, with inputs `code_in` and `last_code` and a 2-bit class output. The FSM and counters live in `moore_seq_decoder`.

## Test plan
All scenarios use default parameters and `code_valid`=1 unless stated.

- Reset: hold `rst` for 2 cycles, then release → all outputs 0, `state`=0.
- Lock: feed 1,2,3,1 → `step` pulses on samples 2–4. After the 4th sample: `state`=2, `locked`=1, `step_count`=3, `last_code`=1.
- Hold and gaps: in LOCKED, feed 2,2 with `code_valid`=0 for 3 cycles between them → one `step` then one `hold`. `step_count` advances by 1, and nothing changes during the gap.
- Single error: in LOCKED with `last_code`=2, feed 1 then 2 → `err` (`state`=3, `last_code`=1), then `step` (`state`=2).
- Error limit: in LOCKED with `last_code`=3, feed 3 then 0 then 0:
  - 3 → `hold`, `state` stays 2.
  - first 0 → `err`, `state`=3, `bad_cnt`=1, `last_code` stays 3.
  - second 0 → `err`, `bad_cnt`=2, `state`=0, `locked`=0, `last_code`=0.
- Wrap and reset mid-run: with `CNT_W`=2, lock (`step_count`=3), then one more step → `step_count`=0. Assert `rst` on the next cycle with a valid code present → no pulse, all outputs return to reset values.

Source files
------------

// File: rtl/moore_seq_pkg.sv
// Shared encodings for the Moore sequence decoder: FSM states, generator codes,
// sample classes and the legal-successor function of the 1->2->3->1 code cycle.
package moore_seq_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    STEP = 2'd1,
    ERR  = 2'd2
  } code_class_t;

  localparam logic [1:0] CODE_0 = 2'd0;
  localparam logic [1:0] CODE_A = 2'd1;
  localparam logic [1:0] CODE_B = 2'd2;
  localparam logic [1:0] CODE_C = 2'd3;

  // Code 0 has no successor; mapping it to 0 keeps it out of the STEP class.
  function automatic logic [1:0] succ(input logic [1:0] code);
    case (code)
      CODE_A:  succ = CODE_B;
      CODE_B:  succ = CODE_C;
      CODE_C:  succ = CODE_A;
      default: succ = CODE_0;
    endcase
  endfunction

endpackage

// File: rtl/moore_code_classifier.sv
// Combinational classification of an observed code against the last accepted
// reference code: hold, legal advance, or illegal transition.
module moore_code_classifier
  import moore_seq_pkg::*;
(
  input  logic [1:0]  code_in,
  input  logic [1:0]  last_code,
  output code_class_t code_class
);

  // Hold is tested first so a repeated code never counts as an advance.
  always_comb begin
    code_class = ERR;
    if (code_in == last_code) begin
      code_class = HOLD;
    end else if (code_in == succ(last_code)) begin
      code_class = STEP;
    end else begin
      code_class = ERR;
    end
  end

endmodule

// File: rtl/moore_seq_decoder.sv
// Receive-side decoder for the generator's cyclic code: classifies each valid
// sample, tracks lock with a SEARCH/ACQUIRE/LOCKED/RECOVER FSM, counts advances.
module moore_seq_decoder
  import moore_seq_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int ERR_LIMIT  = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       code_in,
  input  logic             code_valid,
  output logic             step,
  output logic             hold,
  output logic             err,
  output logic             locked,
  output logic [1:0]       state,
  output logic [1:0]       last_code,
  output logic [CNT_W-1:0] step_count
);

  state_t             state_r;
  logic [1:0]         last_code_r;
  logic [CNT_W-1:0]   step_count_r;
  logic [3:0]         good_cnt_r;
  logic [3:0]         bad_cnt_r;
  logic               step_r;
  logic               hold_r;
  logic               err_r;
  code_class_t        class_s;
  logic [3:0]         good_next_s;
  logic [3:0]         bad_next_s;

  moore_code_classifier u_classifier (
    .code_in    (code_in),
    .last_code  (last_code_r),
    .code_class (class_s)
  );

  assign good_next_s = good_cnt_r + 4'd1;
  assign bad_next_s  = bad_cnt_r + 4'd1;

  // Lock FSM, reference code, counters and registered event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= SEARCH;
      last_code_r  <= CODE_0;
      step_count_r <= '0;
      good_cnt_r   <= 4'd0;
      bad_cnt_r    <= 4'd0;
      step_r       <= 1'b0;
      hold_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      step_r <= 1'b0;
      hold_r <= 1'b0;
      err_r  <= 1'b0;
      if (code_valid) begin
        case (state_r)
          SEARCH: begin
            if (code_in != CODE_0) begin
              last_code_r <= code_in;
              good_cnt_r  <= 4'd0;
              state_r     <= ACQUIRE;
            end
          end
          ACQUIRE: begin
            case (class_s)
              STEP: begin
                step_r       <= 1'b1;
                step_count_r <= step_count_r + CNT_W'(1);
                last_code_r  <= code_in;
                good_cnt_r   <= good_next_s;
                if (good_next_s >= 4'(LOCK_COUNT)) state_r <= LOCKED;
              end
              HOLD: hold_r <= 1'b1;
              default: begin
                err_r      <= 1'b1;
                good_cnt_r <= 4'd0;
                if (code_in != CODE_0) last_code_r <= code_in;
                else                   state_r     <= SEARCH;
              end
            endcase
          end
          LOCKED: begin
            case (class_s)
              STEP: begin
                step_r       <= 1'b1;
                step_count_r <= step_count_r + CNT_W'(1);
                last_code_r  <= code_in;
              end
              HOLD: hold_r <= 1'b1;
              default: begin
                err_r     <= 1'b1;
                bad_cnt_r <= 4'd1;
                state_r   <= RECOVER;
                if (code_in != CODE_0) last_code_r <= code_in;
              end
            endcase
          end
          RECOVER: begin
            case (class_s)
              STEP: begin
                step_r       <= 1'b1;
                step_count_r <= step_count_r + CNT_W'(1);
                last_code_r  <= code_in;
                bad_cnt_r    <= 4'd0;
                state_r      <= LOCKED;
              end
              HOLD: hold_r <= 1'b1;
              default: begin
                err_r     <= 1'b1;
                bad_cnt_r <= bad_next_s;
                // Hitting the limit abandons the reference entirely.
                if (bad_next_s >= 4'(ERR_LIMIT)) begin
                  state_r     <= SEARCH;
                  last_code_r <= CODE_0;
                  good_cnt_r  <= 4'd0;
                end else if (code_in != CODE_0) begin
                  last_code_r <= code_in;
                end
              end
            endcase
          end
          default: state_r <= SEARCH;
        endcase
      end
    end
  end

  assign step       = step_r;
  assign hold       = hold_r;
  assign err        = err_r;
  assign locked     = state_r[1];
  assign state      = state_r;
  assign last_code  = last_code_r;
  assign step_count = step_count_r;

endmodule

// File: tb/tb_moore_seq_decoder.sv
// Self-checking bench: directed vector table, hand-written wrap/reset sequence,
// and randomized stimulus against a behavioural model of the decoder rules.
module tb_moore_seq_decoder;

  localparam int LOCK_COUNT = 3;
  localparam int ERR_LIMIT  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] code_in;
  logic       code_valid;

  logic       step, hold, err, locked;
  logic [1:0] state, last_code;
  logic [7:0] step_count;
  logic       step2, hold2, err2, locked2;
  logic [1:0] state2, last_code2;
  logic [1:0] step_count2;

  int n_cmp = 0;
  int n_bad = 0;

  moore_seq_decoder u_dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .step(step), .hold(hold), .err(err), .locked(locked), .state(state),
    .last_code(last_code), .step_count(step_count)
  );

  moore_seq_decoder #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .step(step2), .hold(hold2), .err(err2), .locked(locked2), .state(state2),
    .last_code(last_code2), .step_count(step_count2)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int m_state, m_last, m_good, m_bad, m_cnt;
  int m_step, m_hold, m_err;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit v, input int c);
    bit is_hold, is_step;
    m_step = 0; m_hold = 0; m_err = 0;
    if (r) begin
      m_state = 0; m_last = 0; m_good = 0; m_bad = 0; m_cnt = 0;
      return;
    end
    if (!v) return;
    is_hold = (c == m_last);
    is_step = !is_hold && (m_last != 0) && (c == (m_last % 3) + 1);
    if (m_state == 0) begin
      if (c != 0) begin m_last = c; m_good = 0; m_state = 1; end
    end else if (is_hold) begin
      m_hold = 1;
    end else if (is_step) begin
      m_step = 1; m_cnt++; m_last = c;
      if (m_state == 1) begin
        m_good++;
        if (m_good >= LOCK_COUNT) m_state = 2;
      end else if (m_state == 3) begin
        m_bad = 0; m_state = 2;
      end
    end else begin
      m_err = 1;
      if (m_state == 1) begin
        m_good = 0;
        if (c != 0) m_last = c; else m_state = 0;
      end else begin
        m_bad = (m_state == 2) ? 1 : m_bad + 1;
        m_state = 3;
        if (c != 0) m_last = c;
        if (m_bad >= ERR_LIMIT) begin m_state = 0; m_last = 0; m_good = 0; end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".step"},   int'(step),       m_step);
    chk({tag, ".hold"},   int'(hold),       m_hold);
    chk({tag, ".err"},    int'(err),        m_err);
    chk({tag, ".locked"}, int'(locked),     int'(m_state >= 2));
    chk({tag, ".state"},  int'(state),      m_state);
    chk({tag, ".last"},   int'(last_code),  m_last);
    chk({tag, ".count"},  int'(step_count), m_cnt % 256);
    chk({tag, ".pulses2"}, int'({step2, hold2, err2}), m_step * 4 + m_hold * 2 + m_err);
    chk({tag, ".state2"}, int'({locked2, state2, last_code2}),
        int'(m_state >= 2) * 16 + m_state * 4 + m_last);
    chk({tag, ".count2"}, int'(step_count2), m_cnt % 4);
  endtask

  // One clock: drive, let the edge sample, update the model, check after the edge.
  task automatic cycle(input bit r, input bit v, input int c, input string tag);
    rst = r; code_valid = v; code_in = 2'(c);
    @(posedge clk);
    model_update(r, v, c);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    int r; int v; int c;
    int pulse;  // {step,hold,err}
    int st; int last; int cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int r, input int v, input int c, input int p,
                     input int s, input int l, input int n);
    vec_t e;
    e.r = r; e.v = v; e.c = c; e.pulse = p; e.st = s; e.last = l; e.cnt = n;
    tbl.push_back(e);
  endtask

  initial begin
    rst = 1'b1; code_valid = 1'b0; code_in = 2'd0;
    // reset held two cycles, then released idle
    add(1, 0, 0, 3'b000, 0, 0, 0);
    add(1, 1, 1, 3'b000, 0, 0, 0);
    add(0, 0, 0, 3'b000, 0, 0, 0);
    // lock on 1,2,3,1
    add(0, 1, 1, 3'b000, 1, 1, 0);
    add(0, 1, 2, 3'b100, 1, 2, 1);
    add(0, 1, 3, 3'b100, 1, 3, 2);
    add(0, 1, 1, 3'b100, 2, 1, 3);
    // step, 3-cycle gap, hold
    add(0, 1, 2, 3'b100, 2, 2, 4);
    add(0, 0, 3, 3'b000, 2, 2, 4);
    add(0, 0, 1, 3'b000, 2, 2, 4);
    add(0, 0, 0, 3'b000, 2, 2, 4);
    add(0, 1, 2, 3'b010, 2, 2, 4);
    // single error then recovery
    add(0, 1, 1, 3'b001, 3, 1, 4);
    add(0, 1, 2, 3'b100, 2, 2, 5);
    // error limit
    add(0, 1, 3, 3'b100, 2, 3, 6);
    add(0, 1, 3, 3'b010, 2, 3, 6);
    add(0, 1, 0, 3'b001, 3, 3, 6);
    add(0, 1, 0, 3'b001, 0, 0, 6);
    // SEARCH ignores 0; ACQUIRE skip resyncs, 0 returns to SEARCH
    add(0, 1, 0, 3'b000, 0, 0, 6);
    add(0, 1, 2, 3'b000, 1, 2, 6);
    add(0, 1, 1, 3'b001, 1, 1, 6);
    add(0, 1, 0, 3'b001, 0, 1, 6);

    foreach (tbl[i]) begin
      cycle(tbl[i].r[0], tbl[i].v[0], tbl[i].c, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.pulse", i), int'({step, hold, err}), tbl[i].pulse);
      chk($sformatf("tbl%0d.state", i), int'(state), tbl[i].st);
      chk($sformatf("tbl%0d.locked", i), int'(locked), int'(tbl[i].st >= 2));
      chk($sformatf("tbl%0d.last", i), int'(last_code), tbl[i].last);
      chk($sformatf("tbl%0d.cnt", i), int'(step_count), tbl[i].cnt);
    end

    // Wrap of a 2-bit counter, then reset with a valid code present
    cycle(1, 0, 0, "wrap.rst");
    cycle(0, 1, 1, "wrap.s1");
    cycle(0, 1, 2, "wrap.s2");
    cycle(0, 1, 3, "wrap.s3");
    cycle(0, 1, 1, "wrap.s4");
    chk("wrap.lock_cnt2", int'(step_count2), 3);
    chk("wrap.locked2", int'(locked2), 1);
    cycle(0, 1, 2, "wrap.s5");
    chk("wrap.cnt2_zero", int'(step_count2), 0);
    chk("wrap.cnt8", int'(step_count), 4);
    cycle(1, 1, 3, "wrap.midrst");
    chk("midrst.pulses", int'({step, hold, err, step2, hold2, err2}), 0);
    chk("midrst.outs", int'({locked, state, last_code, step_count}), 0);
    chk("midrst.cnt2", int'(step_count2), 0);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      int r, c;
      bit v, rr;
      rr = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 9);
      if (r < 6)      c = (m_last == 0) ? $urandom_range(1, 3) : (m_last % 3) + 1;
      else if (r < 8) c = m_last;
      else            c = $urandom_range(0, 3);
      cycle(rr, v, c, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
